// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : regfile_write_arbiter_pkg
// Description : Shared widths, round-robin pointer encoding and the
//               write-request record for the register-file write arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package regfile_write_arbiter_pkg;

  localparam int REGARB_DATA_W = 8;
  localparam int REGARB_ADDR_W = 3;
  localparam int REGARB_NREGS  = 8;

  // Round-robin pointer: which source wins a both-full, different-address contest
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  typedef struct packed {
    logic [REGARB_ADDR_W-1:0] addr;
    logic [REGARB_DATA_W-1:0] data;
  } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_slot.sv
`default_nettype none
// ============================================================================
// Module      : regarb_slot
// Description : One-entry holding buffer for a writeback source.
//   clk, Reset        clock / asynchronous active-low reset
//   load              capture in_addr/in_data (only asserted while ready)
//   in_addr, in_data  incoming write
//   older_present     the other buffer holds (or is taking) an older entry
//   grant             entry leaves for the output stage this edge
//   other_grant       the other buffer's entry leaves this edge
//   full, ready       occupancy; ready is a registered empty flag
//   addr, data        buffered write
//   younger           this entry arrived after the other buffer's entry
// Revision    : 1.0  initial release
// ============================================================================
module regarb_slot
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = REGARB_DATA_W,
  parameter int ADDR_W = REGARB_ADDR_W
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              older_present,
  input  logic              grant,
  input  logic              other_grant,
  output logic              full,
  output logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              younger
);

  // load and grant are mutually exclusive: load needs ready, grant needs full.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      full    <= 1'b0;
      ready   <= 1'b1;
      addr    <= '0;
      data    <= '0;
      younger <= 1'b0;
    end else if (load) begin
      full    <= 1'b1;
      ready   <= 1'b0;
      addr    <= in_addr;
      data    <= in_data;
      younger <= older_present;
    end else if (grant) begin
      full    <= 1'b0;
      ready   <= 1'b1;
      younger <= 1'b0;
    end else if (other_grant) begin
      // The older entry has retired, so this one is now the oldest.
      younger <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file write port between source A (ALU)
//               and source B (load). Each source has a one-entry buffer;
//               grants are round-robin except same-address writes, which
//               retire oldest first. Exports a pending-write scoreboard.
//   clk, Reset                       clock / asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data    source A handshake and write
//   b_valid/b_ready/b_addr/b_data    source B handshake and write
//   RegWrite/Write_reg_num/Write_data  register file write port
//   pending                          per-register outstanding-write flags
// Configuration macro: REGARB_R0_PROTECT_EN -- writes to register 0 are
//   accepted and silently discarded.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = REGARB_DATA_W,
  parameter int ADDR_W = REGARB_ADDR_W,
  parameter int NREGS  = REGARB_NREGS
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_reg_num,
  output logic [DATA_W-1:0] Write_data,
  output logic [NREGS-1:0]  pending
);

  logic              a_load, b_load;
  logic              a_full, b_full;
  logic [ADDR_W-1:0] a_buf_addr, b_buf_addr;
  logic [DATA_W-1:0] a_buf_data, b_buf_data;
  logic              a_younger, b_younger;
  logic              grant_a, grant_b;
  prio_t             ptr_q, ptr_d;

`ifdef REGARB_R0_PROTECT_EN
  // Handshake still completes for register 0; the write just never loads.
  assign a_load = a_valid & a_ready & (a_addr != '0);
  assign b_load = b_valid & b_ready & (b_addr != '0);
`else
  assign a_load = a_valid & a_ready;
  assign b_load = b_valid & b_ready;
`endif

  regarb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .clk           (clk),
    .Reset         (Reset),
    .load          (a_load),
    .in_addr       (a_addr),
    .in_data       (a_data),
    .older_present (b_full & ~grant_b),
    .grant         (grant_a),
    .other_grant   (grant_b),
    .full          (a_full),
    .ready         (a_ready),
    .addr          (a_buf_addr),
    .data          (a_buf_data),
    .younger       (a_younger)
  );

  // A accepted on the same edge counts as older than B.
  regarb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .clk           (clk),
    .Reset         (Reset),
    .load          (b_load),
    .in_addr       (b_addr),
    .in_data       (b_data),
    .older_present (a_load | (a_full & ~grant_a)),
    .grant         (grant_b),
    .other_grant   (grant_a),
    .full          (b_full),
    .ready         (b_ready),
    .addr          (b_buf_addr),
    .data          (b_buf_data),
    .younger       (b_younger)
  );

  // Arbitration and pointer next-state
  always_comb begin
    grant_a = a_full;
    ptr_d   = ptr_q;
    if (a_full && b_full) begin
      if (a_buf_addr == b_buf_addr) begin
        grant_a = ~a_younger;
      end else begin
        grant_a = (ptr_q == PRIO_A);
      end
      ptr_d = grant_a ? PRIO_B : PRIO_A;
    end
    grant_b = b_full & ~grant_a;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ptr_q <= PRIO_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Output stage: the granted entry drives the write port for one cycle.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      RegWrite      <= 1'b0;
      Write_reg_num <= '0;
      Write_data    <= '0;
    end else begin
      RegWrite <= grant_a | grant_b;
      if (grant_a) begin
        Write_reg_num <= a_buf_addr;
        Write_data    <= a_buf_data;
      end else if (grant_b) begin
        Write_reg_num <= b_buf_addr;
        Write_data    <= b_buf_data;
      end
    end
  end

  // Scoreboard: decode the post-edge occupancy so pending is registered.
  logic              a_full_d, b_full_d;
  logic [ADDR_W-1:0] a_addr_d, b_addr_d, out_addr_d;
  logic [NREGS-1:0]  pending_d;

  assign a_full_d   = a_load | (a_full & ~grant_a);
  assign b_full_d   = b_load | (b_full & ~grant_b);
  assign a_addr_d   = a_load ? a_addr : a_buf_addr;
  assign b_addr_d   = b_load ? b_addr : b_buf_addr;
  assign out_addr_d = grant_a ? a_buf_addr : b_buf_addr;

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if ((a_full_d && (a_addr_d == ADDR_W'(i))) ||
          (b_full_d && (b_addr_d == ADDR_W'(i))) ||
          ((grant_a || grant_b) && (out_addr_d == ADDR_W'(i)))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pending <= '0;
    end else begin
      pending <= pending_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter. A sequence-
//               numbered buffer model predicts ready/write/pending every
//               cycle; directed scenarios pin the model with literal values.
//               Honours REGARB_R0_PROTECT_EN like the design.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, RegWrite;
  logic [2:0] Write_reg_num;
  logic [7:0] Write_data;
  logic [7:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter dut (
    .clk           (clk),
    .Reset         (Reset),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .RegWrite      (RegWrite),
    .Write_reg_num (Write_reg_num),
    .Write_data    (Write_data),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each buffer holds an entry stamped with an arrival sequence number;
  // the smaller number is the older write.
  typedef struct {
    bit         full;
    logic [2:0] addr;
    logic [7:0] data;
    int         seq;
  } ment_t;

  ment_t      ma, mb;
  int         seq_ctr;
  bit         m_pref_b;     // next different-address contest goes to B
  bit         m_ov;
  logic [2:0] m_oa;
  logic [7:0] m_od;

  function automatic bit keeps(input logic [2:0] addr);
`ifdef REGARB_R0_PROTECT_EN
    return addr != 3'd0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ma = '{0, 3'd0, 8'd0, 0};
      mb = '{0, 3'd0, 8'd0, 0};
      seq_ctr = 0; m_pref_b = 0;
      m_ov = 0; m_oa = '0; m_od = '0;
    end else begin
      bit acc_a, acc_b, ga, gb;
      acc_a = a_valid && !ma.full;
      acc_b = b_valid && !mb.full;
      if (ma.full && mb.full) begin
        if (ma.addr == mb.addr) ga = (ma.seq < mb.seq);
        else                    ga = !m_pref_b;
        gb = !ga;
        m_pref_b = ga;
      end else begin
        ga = ma.full;
        gb = mb.full;
      end
      m_ov = ga || gb;
      if (ga) begin m_oa = ma.addr; m_od = ma.data; ma.full = 0; end
      if (gb) begin m_oa = mb.addr; m_od = mb.data; mb.full = 0; end
      if (acc_a && keeps(a_addr)) begin
        ma.full = 1; ma.addr = a_addr; ma.data = a_data; ma.seq = seq_ctr; seq_ctr++;
      end
      if (acc_b && keeps(b_addr)) begin
        mb.full = 1; mb.addr = b_addr; mb.data = b_data; mb.seq = seq_ctr; seq_ctr++;
      end
    end
  end

  function automatic logic [7:0] model_pending();
    logic [7:0] p = '0;
    if (ma.full) p[ma.addr] = 1'b1;
    if (mb.full) p[mb.addr] = 1'b1;
    if (m_ov)    p[m_oa]    = 1'b1;
    return p;
  endfunction

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("a_ready",       {31'd0, a_ready},  {31'd0, !ma.full});
    chk("b_ready",       {31'd0, b_ready},  {31'd0, !mb.full});
    chk("RegWrite",      {31'd0, RegWrite}, {31'd0, m_ov});
    chk("Write_reg_num", {29'd0, Write_reg_num}, {29'd0, m_oa});
    chk("Write_data",    {24'd0, Write_data},    {24'd0, m_od});
    chk("pending",       {24'd0, pending},       {24'd0, model_pending()});
  end

  // Log of writes actually presented to the register file.
  wr_req_t wlog[$];
  always @(negedge clk) begin
    if (Reset === 1'b1 && RegWrite === 1'b1) begin
      wr_req_t e;
      e.addr = Write_reg_num;
      e.data = Write_data;
      wlog.push_back(e);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input logic [2:0] aa, input logic [7:0] ad,
                       input bit bv, input logic [2:0] ba, input logic [7:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [2:0] addr, input logic [7:0] data);
    wr_req_t got, exp;
    exp.addr = addr;
    exp.data = data;
    got = (idx < wlog.size()) ? wlog[idx] : '1;
    chk(name, {21'd0, got}, {21'd0, exp});
  endtask

  typedef struct {
    bit av; logic [2:0] aa; logic [7:0] ad;
    bit bv; logic [2:0] ba; logic [7:0] bd;
  } vec_t;

  vec_t vecs[8] = '{
    '{1, 3'd1, 8'h01, 1, 3'd1, 8'h02},
    '{1, 3'd2, 8'h03, 1, 3'd7, 8'h04},
    '{1, 3'd7, 8'h05, 0, 3'd0, 8'h00},
    '{1, 3'd7, 8'h06, 1, 3'd7, 8'h07},
    '{0, 3'd0, 8'h00, 1, 3'd3, 8'h08},
    '{1, 3'd3, 8'h09, 1, 3'd3, 8'h0A},
    '{1, 3'd5, 8'h0B, 1, 3'd6, 8'h0C},
    '{1, 3'd6, 8'h0D, 1, 3'd5, 8'h0E}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int acc_c[4];
    bit pre;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_ready", {31'd0, a_ready}, 32'd1);
    chk("reset_pending", {24'd0, pending}, 32'd0);
    Reset = 1'b1;
    tick();

    // Single A write to r3
    wlog.delete();
    drive(1, 3'd3, 8'h5A, 0, 3'd0, 8'h00);
    tick();
    chk("t2_pending_c0", {24'd0, pending}, 32'h08);
    chk("t2_a_ready_c0", {31'd0, a_ready}, 32'd0);
    a_valid = 1'b0;
    tick();
    chk("t2_regwrite_c1", {31'd0, RegWrite}, 32'd1);
    chk("t2_num_c1",      {29'd0, Write_reg_num}, 32'd3);
    chk("t2_data_c1",     {24'd0, Write_data}, 32'h5A);
    chk("t2_pending_c1",  {24'd0, pending}, 32'h08);
    tick();
    chk("t2_pending_c2",  {24'd0, pending}, 32'h00);
    chk("t2_regwrite_c2", {31'd0, RegWrite}, 32'd0);
    idle(2);

    // Round-robin alternation
    wlog.delete();
    drive(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
    tick();
    idle(3);
    drive(1, 3'd4, 8'h44, 1, 3'd5, 8'h55);
    tick();
    idle(4);
    chk("t3_count", wlog.size(), 32'd4);
    chk_log("t3_w0", 0, 3'd1, 8'h11);
    chk_log("t3_w1", 1, 3'd2, 8'h22);
    chk_log("t3_w2", 2, 3'd5, 8'h55);
    chk_log("t3_w3", 3, 3'd4, 8'h44);

    // Same address: staggered, then same edge twice (second with pointer at B)
    wlog.delete();
    drive(1, 3'd6, 8'hAA, 0, 3'd0, 8'h00);
    tick();
    drive(0, 3'd0, 8'h00, 1, 3'd6, 8'hBB);
    tick();
    idle(4);
    drive(1, 3'd6, 8'hAA, 1, 3'd6, 8'hBB);
    tick();
    chk("t4_pending_same", {24'd0, pending}, 32'h40);
    idle(4);
    drive(1, 3'd6, 8'hA1, 1, 3'd6, 8'hB1);
    tick();
    idle(4);
    chk("t4_count", wlog.size(), 32'd6);
    chk_log("t4_w0", 0, 3'd6, 8'hAA);
    chk_log("t4_w1", 1, 3'd6, 8'hBB);
    chk_log("t4_w2", 2, 3'd6, 8'hAA);
    chk_log("t4_w3", 3, 3'd6, 8'hBB);
    chk_log("t4_w4", 4, 3'd6, 8'hA1);
    chk_log("t4_w5", 5, 3'd6, 8'hB1);

    // A holds valid for four back-to-back writes
    wlog.delete();
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      a_valid = 1'b1;
      a_addr  = 3'(k + 1);
      a_data  = 8'hC0 + 8'(k);
      pre = a_ready;
      tick();
      if (pre) begin
        acc_c[k] = c;
        k++;
      end
    end
    idle(4);
    chk("t5_accepted", k, 32'd4);
    chk("t5_acc_last", acc_c[3], 32'd6);
    chk("t5_count", wlog.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk_log("t5_order", i, 3'(i + 1), 8'hC0 + 8'(i));

    // Mixed directed vectors, checked by the model only
    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
      tick();
    end
    idle(4);

    // Write to register 0
    wlog.delete();
    drive(1, 3'd0, 8'h77, 0, 3'd0, 8'h00);
    tick();
    a_valid = 1'b0;
`ifdef REGARB_R0_PROTECT_EN
    chk("t6_a_ready", {31'd0, a_ready}, 32'd1);
    chk("t6_pending", {24'd0, pending}, 32'd0);
    idle(3);
    chk("t6_count", wlog.size(), 32'd0);
`else
    chk("t6_a_ready", {31'd0, a_ready}, 32'd0);
    chk("t6_pending", {24'd0, pending}, 32'd1);
    idle(3);
    chk("t6_count", wlog.size(), 32'd1);
    chk_log("t6_w0", 0, 3'd0, 8'h77);
`endif

    // Reset mid-run with both buffers full
    drive(1, 3'd1, 8'h31, 1, 3'd2, 8'h32);
    tick();
    chk("t1_pending_before", {24'd0, pending}, 32'h06);
    chk("t1_b_ready_before", {31'd0, b_ready}, 32'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1 Reset = 1'b0;
    #1;
    chk("t1_a_ready", {31'd0, a_ready}, 32'd1);
    chk("t1_b_ready", {31'd0, b_ready}, 32'd1);
    chk("t1_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("t1_pending", {24'd0, pending}, 32'd0);
    tick();
    tick();
    Reset = 1'b1;
    wlog.delete();
    idle(3);
    chk("t1_no_write_after", wlog.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
